// File: rtl/branch_resolve.sv
// Branch resolution: in-order queue of fetch predictions, resolved at EX,
// producing predictor updates, mispredict flushes and statistics.
module branch_resolve #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pred_valid,
    input  logic             pred_taken,
    input  logic [31:0]      pred_pc,
    input  logic [31:0]      pred_target,
    output logic             pred_ready,
    input  logic             ex_valid,
    input  logic             ex_is_br,
    input  logic             ex_taken,
    input  logic [31:0]      ex_target,
    output logic             update,
    output logic [31:0]      PC_update,
    output logic [31:0]      PC_target,
    output logic             BR,
    output logic             flush,
    output logic [31:0]      redirect_pc,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] miss_count,
    output logic             queue_empty,
    output logic             err
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic          tk_mem [DEPTH];
    logic [31:0]   pc_mem [DEPTH];
    logic [31:0]   tg_mem [DEPTH];

    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic             update_q, update_d;
    logic [31:0]      pcu_q, pcu_d;
    logic [31:0]      pct_q, pct_d;
    logic             br_q, br_d;
    logic             flush_q, flush_d;
    logic [31:0]      redir_q, redir_d;
    logic [CNT_W-1:0] brc_q, brc_d;
    logic [CNT_W-1:0] miss_q, miss_d;
    logic             err_q, err_d;

    logic        full;
    logic        empty;
    logic        head_tk;
    logic [31:0] head_pc;
    logic [31:0] head_tg;
    logic [31:0] head_seq;
    logic [31:0] head_npc;
    logic [31:0] exp_npc;
    logic        pop;
    logic        push;
    logic        mispred;
    logic        err_set;

    assign full        = (cnt_q == CW'(DEPTH));
    assign empty       = (cnt_q == '0);
    assign pred_ready  = ~full;
    assign queue_empty = empty;

    assign head_tk  = tk_mem[rptr_q];
    assign head_pc  = pc_mem[rptr_q];
    assign head_tg  = tg_mem[rptr_q];
    assign head_seq = head_pc + 32'd4;
    assign head_npc = head_tk ? head_tg : head_seq;
    assign exp_npc  = (ex_taken && ex_is_br) ? ex_target : head_seq;

    assign pop     = ex_valid && !empty;
    assign mispred = pop && (head_npc != exp_npc);
    // A full queue still accepts a push when the head leaves the same cycle.
    assign push    = pred_valid && (!full || pop) && !mispred;
    assign err_set = (pred_valid && full && !pop) || (ex_valid && empty);

    always_comb begin
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        cnt_d    = cnt_q;
        update_d = 1'b0;
        pcu_d    = pcu_q;
        pct_d    = pct_q;
        br_d     = br_q;
        flush_d  = 1'b0;
        redir_d  = redir_q;
        brc_d    = brc_q;
        miss_d   = miss_q;
        err_d    = err_q | err_set;

        if (mispred) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end else begin
            rptr_d = rptr_q + PW'(pop);
            wptr_d = wptr_q + PW'(push);
            cnt_d  = cnt_q + CW'(push) - CW'(pop);
        end

        if (pop && (ex_is_br || head_tk)) begin
            update_d = 1'b1;
            pcu_d    = head_pc;
            pct_d    = ex_target;
            br_d     = ex_is_br && ex_taken;
        end

        if (mispred) begin
            flush_d = 1'b1;
            redir_d = exp_npc;
        end

        if (pop && ex_is_br && (brc_q != '1))
            brc_d = brc_q + CNT_W'(1);
        if (mispred && (miss_q != '1))
            miss_d = miss_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            tk_mem[wptr_q] <= pred_taken;
            pc_mem[wptr_q] <= pred_pc;
            tg_mem[wptr_q] <= pred_target;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            cnt_q    <= '0;
            update_q <= 1'b0;
            pcu_q    <= '0;
            pct_q    <= '0;
            br_q     <= 1'b0;
            flush_q  <= 1'b0;
            redir_q  <= '0;
            brc_q    <= '0;
            miss_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            cnt_q    <= cnt_d;
            update_q <= update_d;
            pcu_q    <= pcu_d;
            pct_q    <= pct_d;
            br_q     <= br_d;
            flush_q  <= flush_d;
            redir_q  <= redir_d;
            brc_q    <= brc_d;
            miss_q   <= miss_d;
            err_q    <= err_d;
        end
    end

    assign update      = update_q;
    assign PC_update   = pcu_q;
    assign PC_target   = pct_q;
    assign BR          = br_q;
    assign flush       = flush_q;
    assign redirect_pc = redir_q;
    assign br_count    = brc_q;
    assign miss_count  = miss_q;
    assign err         = err_q;

endmodule
